i2c_target: RTL
===============

# i2c_target

I2C target (slave) responder, the far end of the peripheral subsystem's I2C controller on the `i2c_scl_*`/`i2c_sda_*` pins. It exposes a byte-wide register file that an external controller writes and reads with standard 7-bit-address transactions, using an auto-incrementing register pointer. It also provides a local read port and write notification to the surrounding logic. It is used in subsystem benches as the bus responder and as a reusable on-chip target.

## Interface
Parameters:
- `ADDR`, 7'h50, 7-bit target address.
- `REGS`, 16, number of 8-bit registers (power of two, 2..256); `PW = $clog2(REGS)`.
- `STRETCH`, 8, SCL low-hold length in `pclk` cycles (used only with the configuration macro).

Ports (one clock, `pclk`; reset `preset`, asynchronous, active-high):
- `pclk`  in  1  system clock.
- `preset`  in  1  async active-high reset.
- `i2c_scl_i`  in  1  SCL pin level.
- `i2c_scl_o`  out  1  SCL drive value, constant 0.
- `i2c_scl_e`  out  1  SCL pull-low enable.
- `i2c_sda_i`  in  1  SDA pin level.
- `i2c_sda_o`  out  1  SDA drive value, constant 0.
- `i2c_sda_e`  out  1  SDA pull-low enable; 1 drives low.
- `loc_addr`  in  PW  local read index.
- `loc_rdata`  out  8  `regs[loc_addr]`, registered.
- `wr_pulse`  out  1  one-cycle pulse per committed data byte.
- `wr_idx`  out  PW  index written; valid with `wr_pulse`.
- `busy`  out  1  high from address match until STOP or a non-matching repeated START.

## Operation
- **Input sync and edge detect.** SCL and SDA pass through 2-FF synchronizers, then edge detection runs on the synchronized levels.
  - START or repeated START (Sr): SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- **Bit timing.** SDA is sampled on the synchronized SCL rise. `i2c_sda_e` changes only on the synchronized SCL fall.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
- **START or Sr**, from any state → ADDR: bit counter cleared, shift register cleared.
- **STOP**, from any state → IDLE: SDA released, `busy`=0.
- **ADDR.** Shift 8 bits, MSB first.
  - `[7:1]==ADDR` → ADDR_ACK, driving SDA low for bit 9. After ACK: R/W=0 → PTR; R/W=1 → load `regs[ptr]` → RDATA.
  - Mismatch → IGNORE with SDA released (NACK).
- **PTR.** First byte after a write address.
  - Value < REGS → ACK and load `ptr`.
  - Otherwise → NACK, then IGNORE, `ptr` unchanged.
- **WDATA.** Each byte is ACKed. On the ACK SCL rise: `regs[ptr]` is written, `wr_pulse`=1 with `wr_idx`=`ptr`, then `ptr` = `ptr`+1 mod REGS (wrap REGS-1 → 0).
- **RDATA.** Drive the shift register MSB first: `sda_e` = ~bit. After 8 bits, release SDA → RACK.
- **RACK.** Sample the controller's ACK.
  - ACK (0): `ptr`++ with wrap, reload, → RDATA.
  - NACK (1): → IGNORE.
- **Pointer persistence.** `ptr` persists across transactions. A write-address, then Sr, then read-address sequence reads from the pointer just set.
- **Local port.** `loc_rdata` = `regs[loc_addr]`, registered, 1-cycle latency. A same-cycle I2C write to the same index returns the old value that cycle and the new value the next.
- **Reset, including mid-transfer.** All outputs 0: SDA and SCL released at once (asynchronous). `regs`=0, `ptr`=0, state=IDLE.

## Timing
- Pin edge → internal event: 2 `pclk` cycles.
- `sda_e` update: 3 `pclk` after the SCL falling pin edge.
- SCL high and SCL low must each be ≥ 4 `pclk` periods. Faster buses are unsupported.
- `wr_pulse`: exactly 1 cycle, 3 `pclk` after the SCL rise of the ACK bit.
- START/STOP during a byte aborts it; a partial byte is never written.
- If STOP and a data-byte commit would coincide, the commit occurs and the state goes to IDLE.

## Configuration
- Macro: `I2C_TARGET_STRETCH_EN`.
- **Defined:** after every bit-9 (ACK/NACK) SCL fall, and only while not in IDLE or IGNORE, `i2c_scl_e`=1 for exactly `STRETCH` `pclk` cycles, then released. SCL edges seen during the hold are ignored.
- **Undefined:** `i2c_scl_e` is tied to 0 and `STRETCH` is unused.

## Test plan
- **Write burst.** S, 0xA0, 0x03, 0x11, 0x22, P.
  - All four bytes ACKed; `regs[3]`=0x11, `regs[4]`=0x22.
  - Two `wr_pulse` with `wr_idx` 3 then 4; `loc_addr`=4 gives `loc_rdata`=0x22.
- **Combined read.** After the write burst: S, 0xA0, 0x03, Sr, 0xA1, then read two bytes (controller ACK, then NACK), P.
  - Returns 0x11, 0x22; `ptr` ends at 5; `busy` falls at P.
- **Address mismatch.** S, 0xA2, then 0x55.
  - `sda_e`=0 throughout both bytes; no `wr_pulse`; `busy`=0.
- **Wrap and range.**
  - S, 0xA0, 0x0F, 0xAA, 0xBB, P → `regs[15]`=0xAA, `regs[0]`=0xBB.
  - S, 0xA0, 0x10 → NACK; `ptr` unchanged.
- **Reset mid-read.** Assert `preset` while SDA is driven low in RDATA.
  - `sda_e`=0 in the same cycle; all regs 0.
  - The next read of index 0 returns 0x00.
- **Stretch (macro defined, `STRETCH`=8).** Run the write burst.
  - After each ACK, `scl_e`=1 for exactly 8 cycles.
  - Data is identical to the first scenario.

Source files
------------

// File: rtl/i2c_target.sv
// ---------------------------------------------------------------------------
// i2c_target
// I2C target (slave) responder with a byte-wide register file, accessed by an
// external controller through 7-bit-address transactions and an
// auto-incrementing register pointer. A local registered read port and a
// per-byte write notification serve the surrounding logic.
//
// Parameters:
//   ADDR     7-bit target address
//   REGS     number of 8-bit registers (power of two, 2..256), PW = $clog2(REGS)
//   STRETCH  SCL low-hold length in pclk cycles (clock-stretch build only)
//
// Ports:
//   pclk, preset            clock, asynchronous active-high reset
//   i2c_scl_i / _o / _e     SCL level in, drive value (0), pull-low enable
//   i2c_sda_i / _o / _e     SDA level in, drive value (0), pull-low enable
//   loc_addr / loc_rdata    local read index, registered read data
//   wr_pulse / wr_idx       one-cycle pulse per committed byte, index written
//   busy                    addressed, until STOP or non-matching repeated START
//
// Build option: define I2C_TARGET_STRETCH_EN to hold SCL low for STRETCH
// cycles after every ACK/NACK bit while the transaction is still live.
// ---------------------------------------------------------------------------
module i2c_target #(
    parameter logic [6:0]  ADDR    = 7'h50,
    parameter int unsigned REGS    = 16,
    parameter int unsigned STRETCH = 8,
    localparam int unsigned PW     = $clog2(REGS)
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic          i2c_scl_i,
    output logic          i2c_scl_o,
    output logic          i2c_scl_e,
    input  logic          i2c_sda_i,
    output logic          i2c_sda_o,
    output logic          i2c_sda_e,
    input  logic [PW-1:0] loc_addr,
    output logic [7:0]    loc_rdata,
    output logic          wr_pulse,
    output logic [PW-1:0] wr_idx,
    output logic          busy
);

    if ((REGS < 2) || (REGS > 256) || ((REGS & (REGS - 1)) != 0) || (STRETCH < 1)) begin : g_bad_cfg
        $error("i2c_target: unsupported REGS/STRETCH configuration");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
    } state_t;

    // [0] first sync stage, [1] synchronized level, [2] previous level
    logic [2:0]    scl_sync_q, scl_sync_d;
    logic [2:0]    sda_sync_q, sda_sync_d;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    sh_q, sh_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [7:0]    regs_q [REGS];
    logic [7:0]    regs_d [REGS];
    logic          sda_e_q, sda_e_d;
    logic          busy_q, busy_d;
    logic          wr_pulse_q, wr_pulse_d;
    logic [PW-1:0] wr_idx_q, wr_idx_d;
    logic [7:0]    loc_rdata_q, loc_rdata_d;

    logic          scl_s, sda_s;
    logic          scl_rise, scl_fall;
    logic          start_ev, stop_ev;
    logic          hold;
    logic [7:0]    byte_in;
    logic          last_bit;
    logic [PW-1:0] ptr_inc;

    assign scl_sync_d = {scl_sync_q[1:0], i2c_scl_i};
    assign sda_sync_d = {sda_sync_q[1:0], i2c_sda_i};
    assign scl_s      = scl_sync_q[1];
    assign sda_s      = sda_sync_q[1];

    // SCL edges are masked while this target is itself holding SCL low.
    assign scl_rise = scl_s & ~scl_sync_q[2] & ~hold;
    assign scl_fall = ~scl_s & scl_sync_q[2] & ~hold;
    assign start_ev = ~sda_s & sda_sync_q[2] & scl_s;
    assign stop_ev  = sda_s & ~sda_sync_q[2] & scl_s;

    assign byte_in  = {sh_q[6:0], sda_s};
    assign last_bit = (cnt_q == 3'd7);
    assign ptr_inc  = ptr_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        ptr_d       = ptr_q;
        regs_d      = regs_q;
        sda_e_d     = sda_e_q;
        busy_d      = busy_q;
        wr_pulse_d  = 1'b0;
        wr_idx_d    = wr_idx_q;
        loc_rdata_d = regs_q[loc_addr];

        // Bits are sampled, and byte/ACK decisions taken, on SCL rise.
        if (scl_rise) begin
            case (state_q)
                S_ADDR: begin
                    sh_d  = byte_in;
                    cnt_d = cnt_q + 3'd1;
                    if (last_bit) begin
                        if (byte_in[7:1] == ADDR) begin
                            state_d = S_ADDR_ACK;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = S_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    cnt_d = '0;
                    if (sh_q[0]) begin
                        sh_d    = regs_q[ptr_q];
                        state_d = S_RDATA;
                    end else begin
                        state_d = S_PTR;
                    end
                end
                S_PTR: begin
                    sh_d  = byte_in;
                    cnt_d = cnt_q + 3'd1;
                    if (last_bit) begin
                        if ({1'b0, byte_in} < 9'(REGS)) begin
                            ptr_d   = byte_in[PW-1:0];
                            state_d = S_PTR_ACK;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_PTR_ACK: begin
                    cnt_d   = '0;
                    state_d = S_WDATA;
                end
                S_WDATA: begin
                    sh_d  = byte_in;
                    cnt_d = cnt_q + 3'd1;
                    if (last_bit) begin
                        state_d = S_WDATA_ACK;
                    end
                end
                S_WDATA_ACK: begin
                    regs_d[ptr_q] = sh_q;
                    wr_pulse_d    = 1'b1;
                    wr_idx_d      = ptr_q;
                    ptr_d         = ptr_inc;
                    cnt_d         = '0;
                    state_d       = S_WDATA;
                end
                S_RDATA: begin
                    sh_d  = {sh_q[6:0], 1'b0};
                    cnt_d = cnt_q + 3'd1;
                    if (last_bit) begin
                        state_d = S_RACK;
                    end
                end
                S_RACK: begin
                    // The pointer advances past every byte sent, ACKed or not.
                    ptr_d = ptr_inc;
                    cnt_d = '0;
                    if (!sda_s) begin
                        sh_d    = regs_q[ptr_inc];
                        state_d = S_RDATA;
                    end else begin
                        state_d = S_IGNORE;
                    end
                end
                default: ;
            endcase
        end

        // SDA drive only changes while SCL is low.
        if (scl_fall) begin
            case (state_q)
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: sda_e_d = 1'b1;
                S_RDATA:                            sda_e_d = ~sh_q[7];
                default:                            sda_e_d = 1'b0;
            endcase
        end

        // Bus conditions override the state but not a byte commit above.
        if (start_ev) begin
            state_d = S_ADDR;
            cnt_d   = '0;
            sh_d    = '0;
            sda_e_d = 1'b0;
        end
        if (stop_ev) begin
            state_d = S_IDLE;
            sda_e_d = 1'b0;
            busy_d  = 1'b0;
        end
    end

`ifdef I2C_TARGET_STRETCH_EN
    localparam int unsigned SW = $clog2(STRETCH + 1);

    logic          ack9_q, ack9_d;
    logic          scl_e_q, scl_e_d;
    logic [SW-1:0] str_cnt_q, str_cnt_d;

    assign hold      = scl_e_q;
    assign i2c_scl_e = scl_e_q;

    // ack9 marks that the ACK/NACK bit has been clocked; the following SCL
    // fall ends bit 9 and starts the hold.
    always_comb begin
        ack9_d    = ack9_q;
        scl_e_d   = scl_e_q;
        str_cnt_d = str_cnt_q;
        if (start_ev || stop_ev) begin
            ack9_d = 1'b0;
        end else if (scl_rise && (state_q inside {S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK, S_RACK})) begin
            ack9_d = 1'b1;
        end else if (scl_fall && ack9_q) begin
            ack9_d = 1'b0;
            if (!(state_q inside {S_IDLE, S_IGNORE})) begin
                scl_e_d   = 1'b1;
                str_cnt_d = SW'(STRETCH - 1);
            end
        end
        if (scl_e_q) begin
            if (str_cnt_q == '0) begin
                scl_e_d = 1'b0;
            end else begin
                str_cnt_d = str_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ack9_q    <= 1'b0;
            scl_e_q   <= 1'b0;
            str_cnt_q <= '0;
        end else begin
            ack9_q    <= ack9_d;
            scl_e_q   <= scl_e_d;
            str_cnt_q <= str_cnt_d;
        end
    end
`else
    assign hold      = 1'b0;
    assign i2c_scl_e = 1'b0;
`endif

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            ptr_q       <= '0;
            sda_e_q     <= 1'b0;
            busy_q      <= 1'b0;
            wr_pulse_q  <= 1'b0;
            wr_idx_q    <= '0;
            loc_rdata_q <= '0;
            for (int unsigned i = 0; i < REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            ptr_q       <= ptr_d;
            sda_e_q     <= sda_e_d;
            busy_q      <= busy_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_idx_q    <= wr_idx_d;
            loc_rdata_q <= loc_rdata_d;
            regs_q      <= regs_d;
        end
    end

    assign i2c_scl_o = 1'b0;
    assign i2c_sda_o = 1'b0;
    assign i2c_sda_e = sda_e_q;
    assign loc_rdata = loc_rdata_q;
    assign wr_pulse  = wr_pulse_q;
    assign wr_idx    = wr_idx_q;
    assign busy      = busy_q;

endmodule
